// File: rtl/alu_result_fifo_if.sv
// Handshake and data bundle between an ALU result producer/consumer and alu_result_fifo.
// master drives results in and accepts the head entry; slave is the FIFO itself.
interface alu_result_fifo_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] oper;
  logic [7:0] sum;
  logic       c_out;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_oper;
  logic [7:0] out_sum;
  logic       out_c_out;
  logic       out_zero;

  modport master (
    output in_valid, oper, sum, c_out, out_ready,
    input  in_ready, out_valid, out_oper, out_sum, out_c_out, out_zero
  );

  modport slave (
    input  in_valid, oper, sum, c_out, out_ready,
    output in_ready, out_valid, out_oper, out_sum, out_c_out, out_zero
  );
endinterface

// File: rtl/alu_result_fifo.sv
// ALU result FIFO: head visible one cycle after push, in_ready depends only on occupancy, full-offers are dropped (sticky drop_err).
// Define ALU_RESULT_STATS_EN to add saturating stat_total/stat_carry push counters.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic                clk,
  input  logic                rst,
  alu_result_fifo_if.slave    bus,
  output logic [CW-1:0]       count,
  output logic                drop_err
`ifdef ALU_RESULT_STATS_EN
  ,
  output logic [15:0]         stat_total,
  output logic [15:0]         stat_carry
`endif
);

  localparam int AW = CW - 1;

  typedef struct packed {
    logic [2:0] oper;
    logic       c_out;
    logic       zero;
    logic [7:0] sum;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  entry_t          wdat;
  entry_t          head;

  assign bus.in_ready  = (count != CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  assign wdat.oper  = bus.oper;
  assign wdat.c_out = bus.c_out;
  assign wdat.zero  = (bus.sum == 8'h00);
  assign wdat.sum   = bus.sum;

  // Stale storage is masked so an empty FIFO always presents zeros.
  assign head          = bus.out_valid ? mem[rd_ptr] : '0;
  assign bus.out_oper  = head.oper;
  assign bus.out_c_out = head.c_out;
  assign bus.out_zero  = head.zero;
  assign bus.out_sum   = head.sum;

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= wdat;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.in_valid && !bus.in_ready) begin
        drop_err <= 1'b1;
      end
    end
  end

`ifdef ALU_RESULT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_total <= '0;
      stat_carry <= '0;
    end else if (push) begin
      if (stat_total != 16'hFFFF) begin
        stat_total <= stat_total + 1'b1;
      end
      if (bus.c_out && (stat_carry != 16'hFFFF)) begin
        stat_carry <= stat_carry + 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count; SHALL be a power of two, 2..16.
REQ-002 Parameter CW, default 3, counter width; SHALL equal log2(DEPTH)+1.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  ALU result on sum/c_out/oper is valid this cycle.
REQ-006 in_ready  output  1  FIFO can accept a result this cycle.
REQ-007 oper  input  3  operation code that produced the result.
REQ-008 sum  input  8  ALU result byte.
REQ-009 c_out  input  1  ALU carry/borrow out.
REQ-010 out_valid  output  1  head entry is valid.
REQ-011 out_ready  input  1  consumer accepts the head entry.
REQ-012 out_oper/out_sum/out_c_out  output  3/8/1  head entry fields.
REQ-013 out_zero  output  1  head entry sum was 8'h00 at capture.
REQ-014 count  output  CW  current occupancy, 0..DEPTH.
REQ-015 drop_err  output  1  sticky: a result was offered while full.

Function
REQ-016 Entry SHALL be {oper, c_out, zero, sum}, 13 bits; zero computed as (sum == 8'h00) at push.
REQ-017 in_ready SHALL be combinational: 1 when count < DEPTH, else 0; no dependence on out_ready.
REQ-018 Push SHALL occur when in_valid && in_ready; write at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-019 Pop SHALL occur when out_valid && out_ready; rd_ptr increments modulo DEPTH.
REQ-020 out_valid SHALL be 1 exactly when count != 0.
REQ-021 Latency: an entry pushed into an empty FIFO SHALL appear on out_* with out_valid=1 the next cycle.
REQ-022 Head fields SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 When count == 0, out_oper/out_sum/out_c_out/out_zero SHALL drive 0.
REQ-024 Simultaneous push and pop (0 < count < DEPTH): count unchanged, both pointers advance.
REQ-025 Push and pop in the same cycle when count == DEPTH: pop only; offered input SHALL be dropped and drop_err set.
REQ-026 Pop request when empty SHALL be ignored; no pointer or count change.
REQ-027 drop_err SHALL set on any cycle with in_valid=1 and in_ready=0 and stay 1 until reset.
REQ-028 Pointer wrap from DEPTH-1 to 0 SHALL preserve FIFO order.

Reset
REQ-029 rst=1 at a clock edge SHALL zero wr_ptr, rd_ptr, count, drop_err; out_valid=0, out_* = 0 next cycle.
REQ-030 Reset mid-operation SHALL discard all stored entries; any push or pop in that cycle SHALL be ignored.
REQ-031 Storage array contents need not be reset; they are never visible while count == 0.

Configuration
REQ-032 Macro ALU_RESULT_STATS_EN defined: add outputs stat_total (16 bits, pushes accepted) and stat_carry (16 bits, accepted pushes with c_out=1); both saturate at 16'hFFFF and clear on rst.
REQ-033 Macro ALU_RESULT_STATS_EN undefined: stat ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-034 rst 2 cycles, then idle -> count=0, out_valid=0, in_ready=1, drop_err=0, out_sum=8'h00.
REQ-035 Push {oper=3'b000, sum=8'hA2, c_out=0} into empty FIFO, out_ready=0 -> next cycle out_valid=1, out_sum=8'hA2, out_zero=0, count=1.
REQ-036 Push 8'h01,8'h02,8'h03,8'h04 with out_ready=0, then offer 8'h05 -> in_ready=0, drop_err=1, count=4; drain -> 8'h01..8'h04 in order.
REQ-037 Continuous push of 8'h10..8'h1F with out_ready=1 -> count stays 1 after first push, outputs 8'h10..8'h1F in order across pointer wraps.
REQ-038 Push sum=8'h00, c_out=1, oper=3'b011 -> out_zero=1, out_c_out=1, out_oper=3'b011; with ALU_RESULT_STATS_EN, stat_total=1, stat_carry=1.
REQ-039 Fill to count=3, assert rst with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, drop_err=0.
